// File: rtl/msftdvip_mdio_master.sv
`default_nettype none
// ============================================================================
// Module   : msftdvip_mdio_master
// Purpose  : Clause-22 MDIO management master. Accepts one register
//            read/write request at a time, serialises the frame on MDIO with
//            MDC divided down from board_clk, and returns read data on a
//            one-cycle response strobe.
// Ports    : board_clk, rst_n (async, active-low)
//            req_valid_i/req_ready_o/req_we_i/req_phy_i/req_reg_i/req_wdata_i
//                                             - request handshake and fields
//            rsp_valid_o/rsp_rdata_o          - response strobe and read data
//            busy_o                           - frame in progress
//            mdc_o, mdio_o, mdio_oe_o, mdio_i - MDIO pad side
// Revision : 1.0 - initial release
// ============================================================================
module msftdvip_mdio_master #(
    parameter int CLK_DIV      = 10,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        board_clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [4:0]  req_phy_i,
    input  logic [4:0]  req_reg_i,
    input  logic [15:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [15:0] rsp_rdata_o,
    output logic        busy_o,
    output logic        mdc_o,
    output logic        mdio_o,
    output logic        mdio_oe_o,
    input  logic        mdio_i
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_HDR  = 3'd2,
        S_TA   = 3'd3,
        S_DATA = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [7:0] c_div_last  = 8'(CLK_DIV - 1);
    localparam logic [5:0] c_pre_last  = (PREAMBLE_LEN > 0) ? 6'(PREAMBLE_LEN - 1) : 6'd0;
    localparam logic [5:0] c_hdr_last  = 6'd13;
    localparam logic [5:0] c_ta_last   = 6'd1;
    localparam logic [5:0] c_data_last = 6'd15;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_div_cnt;
    logic        r_mdc;
    logic [5:0]  r_bit_cnt;
    logic        r_we;
    logic [31:0] r_shift;      // ST, OP, PHYAD, REGAD, TA, DATA - MSB goes out first
    logic        r_mdio;
    logic        r_oe;
    logic [15:0] r_rd_shift;
    logic [15:0] r_rdata;
    logic [1:0]  r_sync;

    logic w_accept;
    logic w_active;
    logic w_tick;
    logic w_rise;
    logic w_fall;
    logic w_last_bit;

    assign w_accept = (r_state == S_IDLE) & req_valid_i;
    assign w_active = (r_state == S_PRE) | (r_state == S_HDR) |
                      (r_state == S_TA)  | (r_state == S_DATA);
    assign w_tick   = (r_div_cnt == c_div_last);
    assign w_rise   = w_active & w_tick & ~r_mdc;
    assign w_fall   = w_active & w_tick &  r_mdc;

    // Last bit of the current frame section.
    always_comb begin
        w_last_bit = 1'b0;
        case (r_state)
            S_PRE:   w_last_bit = (r_bit_cnt == c_pre_last);
            S_HDR:   w_last_bit = (r_bit_cnt == c_hdr_last);
            S_TA:    w_last_bit = (r_bit_cnt == c_ta_last);
            S_DATA:  w_last_bit = (r_bit_cnt == c_data_last);
            default: w_last_bit = 1'b0;
        endcase
    end

    always_ff @(posedge board_clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Sections advance on the MDC falling edge that ends their last bit.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (req_valid_i) w_state_nxt = (PREAMBLE_LEN > 0) ? S_PRE : S_HDR;
            S_PRE:  if (w_fall && w_last_bit) w_state_nxt = S_HDR;
            S_HDR:  if (w_fall && w_last_bit) w_state_nxt = S_TA;
            S_TA:   if (w_fall && w_last_bit) w_state_nxt = S_DATA;
            S_DATA: if (w_fall && w_last_bit) w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge board_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt  <= 8'd0;
            r_mdc      <= 1'b0;
            r_bit_cnt  <= 6'd0;
            r_we       <= 1'b0;
            r_shift    <= 32'd0;
            r_mdio     <= 1'b1;
            r_oe       <= 1'b0;
            r_rd_shift <= 16'd0;
            r_rdata    <= 16'd0;
            r_sync     <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], mdio_i};
            if (w_accept) begin
                r_div_cnt <= 8'd0;
                r_bit_cnt <= 6'd0;
                r_we      <= req_we_i;
                r_shift   <= {2'b01, (req_we_i ? 2'b01 : 2'b10), req_phy_i, req_reg_i,
                              2'b10, (req_we_i ? req_wdata_i : 16'h0000)};
                // First bit is a preamble one, or ST's leading zero without preamble.
                r_mdio    <= (PREAMBLE_LEN > 0);
                r_oe      <= 1'b1;
            end else if (w_active) begin
                r_div_cnt <= w_tick ? 8'd0 : r_div_cnt + 8'd1;
                if (w_tick) r_mdc <= ~r_mdc;
                if (w_rise && (r_state == S_DATA) && !r_we)
                    r_rd_shift <= {r_rd_shift[14:0], r_sync[1]};
                if (w_fall) begin
                    r_bit_cnt <= w_last_bit ? 6'd0 : r_bit_cnt + 6'd1;
                    case (r_state)
                        S_PRE: if (w_last_bit) r_mdio <= r_shift[31];
                        S_HDR, S_TA: begin
                            r_shift <= {r_shift[30:0], 1'b0};
                            r_mdio  <= r_shift[30];
                            // Reads hand the pad to the PHY from the first TA bit onward.
                            if ((r_state == S_HDR) && w_last_bit && !r_we) r_oe <= 1'b0;
                        end
                        S_DATA: begin
                            if (w_last_bit) begin
                                r_oe    <= 1'b0;
                                r_mdio  <= 1'b1;
                                r_rdata <= r_we ? 16'h0000 : r_rd_shift;
                            end else begin
                                r_shift <= {r_shift[30:0], 1'b0};
                                r_mdio  <= r_shift[30];
                            end
                        end
                        default: ;
                    endcase
                end
            end else begin
                r_div_cnt <= 8'd0;
                r_mdc     <= 1'b0;
            end
        end
    end

    assign req_ready_o = (r_state == S_IDLE);
    assign busy_o      = ~req_ready_o;
    assign rsp_valid_o = (r_state == S_DONE);
    assign rsp_rdata_o = r_rdata;
    assign mdc_o       = r_mdc;
    assign mdio_o      = r_mdio;
    assign mdio_oe_o   = r_oe;

endmodule
`default_nettype wire

// File: tb/tb_msftdvip_mdio_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_msftdvip_mdio_master
// Purpose  : Self-checking bench for msftdvip_mdio_master. Instance 0 uses
//            CLK_DIV=4/PREAMBLE_LEN=32 against a PHY model; instance 1 uses
//            CLK_DIV=255/PREAMBLE_LEN=0. A frame-level model predicts every
//            output cycle by cycle from the time elapsed since accept.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msftdvip_mdio_master;

    logic        board_clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [4:0]  req_phy [2];
    logic [4:0]  req_reg [2];
    logic [15:0] req_wdata [2];
    logic [1:0]  rdy, bsy, rspv, mdc, mdo, oe, mdi;
    logic [31:0] rdata_all;
    logic        phy_drv;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Frame model state
    int          m_busy [2];
    int          m_t [2];
    int          m_acc_cnt [2];
    int          acc_cyc [2];
    logic        m_we [2];
    logic [4:0]  m_phy [2];
    logic [4:0]  m_reg [2];
    logic [15:0] m_wdata [2];
    logic [15:0] m_exp_rdata [2];
    logic [15:0] m_last_rdata [2];
    logic [15:0] exp_regs [32];

    // Observed DUT events
    int          rsp_cnt [2];
    int          rsp_cyc [2];
    logic [15:0] rsp_data [2];
    int          dut_acc [2];
    logic        prev_rdy [2];

    // PHY model and capture
    logic [15:0] phy_regs [32];
    logic [63:0] cap_bits, cap_oe;
    int          cap_n, capb_n;
    logic        capb_first;

    msftdvip_mdio_master #(.CLK_DIV(4), .PREAMBLE_LEN(32)) u_dut0 (
        .board_clk(board_clk), .rst_n(rst_n),
        .req_valid_i(req_valid[0]), .req_ready_o(rdy[0]), .req_we_i(req_we[0]),
        .req_phy_i(req_phy[0]), .req_reg_i(req_reg[0]), .req_wdata_i(req_wdata[0]),
        .rsp_valid_o(rspv[0]), .rsp_rdata_o(rdata_all[15:0]), .busy_o(bsy[0]),
        .mdc_o(mdc[0]), .mdio_o(mdo[0]), .mdio_oe_o(oe[0]), .mdio_i(mdi[0])
    );

    msftdvip_mdio_master #(.CLK_DIV(255), .PREAMBLE_LEN(0)) u_dut1 (
        .board_clk(board_clk), .rst_n(rst_n),
        .req_valid_i(req_valid[1]), .req_ready_o(rdy[1]), .req_we_i(req_we[1]),
        .req_phy_i(req_phy[1]), .req_reg_i(req_reg[1]), .req_wdata_i(req_wdata[1]),
        .rsp_valid_o(rspv[1]), .rsp_rdata_o(rdata_all[31:16]), .busy_o(bsy[1]),
        .mdc_o(mdc[1]), .mdio_o(mdo[1]), .mdio_oe_o(oe[1]), .mdio_i(mdi[1])
    );

    assign mdi[0] = oe[0] ? mdo[0] : phy_drv;
    assign mdi[1] = oe[1] ? mdo[1] : 1'b1;

    initial begin
        board_clk = 1'b0;
        forever #5 board_clk = ~board_clk;
    end

    function automatic int div_of(int k);  return (k == 0) ? 4 : 255; endfunction
    function automatic int pre_of(int k);  return (k == 0) ? 32 : 0;  endfunction
    function automatic int flen(int k);    return (pre_of(k) + 32) * 2 * div_of(k); endfunction
    function automatic logic [15:0] get_rdata(int k);
        return (k == 0) ? rdata_all[15:0] : rdata_all[31:16];
    endfunction

    // Bit b of the frame as it should appear on the wire.
    function automatic logic exp_bit(int k, int b);
        logic [31:0] fr;
        fr = {2'b01, (m_we[k] ? 2'b01 : 2'b10), m_phy[k], m_reg[k], 2'b10,
              (m_we[k] ? m_wdata[k] : 16'h0000)};
        if (b < pre_of(k)) return 1'b1;
        return fr[31 - (b - pre_of(k))];
    endfunction

    task automatic chk(string nm, int k, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst=%0d actual=0x%0h required=0x%0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    // Frame model: advances on board_clk, forgets everything on reset.
    initial begin
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0; m_t[k] = 0; m_acc_cnt[k] = 0; acc_cyc[k] = 0;
            m_last_rdata[k] = 16'h0; m_exp_rdata[k] = 16'h0;
        end
        for (int i = 0; i < 32; i++) exp_regs[i] = 16'(i);
        forever begin
            @(posedge board_clk or negedge rst_n);
            if (!rst_n) begin
                for (int k = 0; k < 2; k++) begin
                    m_busy[k] = 0; m_last_rdata[k] = 16'h0;
                end
            end else if (board_clk) begin
                cyc++;
                for (int k = 0; k < 2; k++) begin
                    if (m_busy[k] != 0) begin
                        if (m_t[k] == flen(k) + 1) begin
                            m_busy[k] = 0;
                            m_last_rdata[k] = m_exp_rdata[k];
                            if (k == 0 && m_we[k]) exp_regs[m_reg[k]] = m_wdata[k];
                        end else begin
                            m_t[k]++;
                        end
                    end else if (req_valid[k]) begin
                        m_we[k] = req_we[k]; m_phy[k] = req_phy[k];
                        m_reg[k] = req_reg[k]; m_wdata[k] = req_wdata[k];
                        m_exp_rdata[k] = (req_we[k] || k != 0) ? 16'h0 : exp_regs[req_reg[k]];
                        m_busy[k] = 1; m_t[k] = 1;
                        m_acc_cnt[k]++; acc_cyc[k] = cyc;
                    end
                end
            end
        end
    end

    // Compare process: every cycle, every output, both instances.
    initial begin
        for (int k = 0; k < 2; k++) begin
            rsp_cnt[k] = 0; rsp_cyc[k] = 0; rsp_data[k] = 16'h0; dut_acc[k] = 0; prev_rdy[k] = 1'b1;
        end
        forever begin
            @(negedge board_clk);
            for (int k = 0; k < 2; k++) begin
                if (!rst_n) begin
                    chk("rst_ready", k, rdy[k], 1);
                    chk("rst_rsp_valid", k, rspv[k], 0);
                    chk("rst_rdata", k, get_rdata(k), 0);
                    chk("rst_mdc", k, mdc[k], 0);
                    chk("rst_mdio", k, mdo[k], 1);
                    chk("rst_oe", k, oe[k], 0);
                end else if (m_busy[k] != 0 && m_t[k] <= flen(k)) begin
                    int   b, ph;
                    logic eo;
                    b  = (m_t[k] - 1) / (2 * div_of(k));
                    ph = (m_t[k] - 1) % (2 * div_of(k));
                    eo = !(!m_we[k] && b >= pre_of(k) + 14);
                    chk("frame_ready", k, rdy[k], 0);
                    chk("frame_busy", k, bsy[k], 1);
                    chk("frame_rsp_valid", k, rspv[k], 0);
                    chk("frame_mdc", k, mdc[k], (ph >= div_of(k)) ? 1 : 0);
                    chk("frame_oe", k, oe[k], eo);
                    if (eo) chk("frame_mdio", k, mdo[k], exp_bit(k, b));
                end else if (m_busy[k] != 0) begin
                    chk("done_rsp_valid", k, rspv[k], 1);
                    chk("done_rdata", k, get_rdata(k), m_exp_rdata[k]);
                    chk("done_mdc", k, mdc[k], 0);
                    chk("done_oe", k, oe[k], 0);
                    chk("done_ready", k, rdy[k], 0);
                end else begin
                    chk("idle_ready", k, rdy[k], 1);
                    chk("idle_busy", k, bsy[k], 0);
                    chk("idle_rsp_valid", k, rspv[k], 0);
                    chk("idle_mdc", k, mdc[k], 0);
                    chk("idle_oe", k, oe[k], 0);
                    chk("idle_rdata", k, get_rdata(k), m_last_rdata[k]);
                end
                if (rst_n) begin
                    if (rspv[k]) begin
                        rsp_cnt[k]++; rsp_cyc[k] = cyc; rsp_data[k] = get_rdata(k);
                    end
                    if (prev_rdy[k] && !rdy[k]) dut_acc[k]++;
                end
                prev_rdy[k] = rdy[k];
            end
        end
    end

    // PHY model on instance 0: decodes frames on MDC rises, answers reads on falls.
    initial begin
        int          ps, cnt, rcnt;
        logic [11:0] hdr;
        logic [17:0] wd;
        logic [4:0]  preg;
        logic [15:0] rword;
        for (int i = 0; i < 32; i++) phy_regs[i] = 16'(i);
        ps = 0; cnt = 0; rcnt = 0; hdr = '0; wd = '0; preg = '0; rword = '0;
        phy_drv = 1'b1;
        forever begin
            @(posedge mdc[0] or negedge mdc[0] or negedge rst_n);
            #1;
            if (!rst_n) begin
                ps = 0; phy_drv = 1'b1;
            end else if (mdc[0]) begin
                case (ps)
                    0: if (oe[0] && !mdi[0]) ps = 1;
                    1: if (mdi[0]) begin ps = 2; cnt = 0; end else ps = 0;
                    2: begin
                        hdr = {hdr[10:0], mdi[0]}; cnt++;
                        if (cnt == 12) begin
                            preg = hdr[4:0];
                            if (hdr[11:10] == 2'b10) begin
                                ps = 4; rcnt = 0; rword = phy_regs[preg];
                            end else begin
                                ps = 3; cnt = 0;
                            end
                        end
                    end
                    3: begin
                        wd = {wd[16:0], mdi[0]}; cnt++;
                        if (cnt == 18) begin phy_regs[preg] = wd[15:0]; ps = 0; end
                    end
                    default: ;
                endcase
            end else if (ps == 4) begin
                rcnt++;
                if (rcnt == 1)       phy_drv = 1'b1;
                else if (rcnt == 2)  phy_drv = 1'b0;
                else if (rcnt <= 18) phy_drv = rword[15 - (rcnt - 3)];
                else begin phy_drv = 1'b1; ps = 0; end
            end
        end
    end

    // Wire samples at every MDC rise (what the PHY sees).
    initial begin
        cap_bits = '0; cap_oe = '0; cap_n = 0;
        forever begin
            @(posedge mdc[0]); #1;
            cap_bits = {cap_bits[62:0], mdi[0]};
            cap_oe   = {cap_oe[62:0], oe[0]};
            cap_n++;
        end
    end
    initial begin
        capb_n = 0; capb_first = 1'b1;
        forever begin
            @(posedge mdc[1]); #1;
            if (capb_n == 0) capb_first = mdi[1];
            capb_n++;
        end
    end

    task automatic send(int k, logic we, logic [4:0] pa, logic [4:0] ra, logic [15:0] wd, bit hold);
        int base, n;
        base = m_acc_cnt[k]; n = 0;
        @(negedge board_clk); #1;
        req_we[k] = we; req_phy[k] = pa; req_reg[k] = ra; req_wdata[k] = wd;
        req_valid[k] = 1'b1;
        while (m_acc_cnt[k] == base && n < 20) begin @(posedge board_clk); #1; n++; end
        chk("accept", k, m_acc_cnt[k] - base, 1);
        if (!hold) req_valid[k] = 1'b0;
    endtask

    task automatic wait_rsp(int k, int target, int limit);
        int n;
        n = 0;
        while (rsp_cnt[k] < target && n < limit) begin @(posedge board_clk); n++; end
        chk("rsp_arrived", k, (rsp_cnt[k] >= target) ? 1 : 0, 1);
    endtask

    task automatic check_reset_outputs(string nm);
        chk({nm, "_ready"}, 0, rdy[0], 1);
        chk({nm, "_busy"}, 0, bsy[0], 0);
        chk({nm, "_rsp_valid"}, 0, rspv[0], 0);
        chk({nm, "_rdata"}, 0, rdata_all[15:0], 0);
        chk({nm, "_mdc"}, 0, mdc[0], 0);
        chk({nm, "_mdio"}, 0, mdo[0], 1);
        chk({nm, "_oe"}, 0, oe[0], 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog inst=0 actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, a, n, base_acc;
        rst_n = 1'b1;
        req_valid = 2'b00; req_we = 2'b00;
        for (int k = 0; k < 2; k++) begin
            req_phy[k] = '0; req_reg[k] = '0; req_wdata[k] = '0;
        end
        #1 rst_n = 1'b0;
        @(negedge board_clk); #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge board_clk);
        #3 rst_n = 1'b1;

        // 1: write phy=1 reg=4 A5A5
        cap_n = 0; r = rsp_cnt[0];
        send(0, 1'b1, 5'd1, 5'd4, 16'hA5A5, 1'b0);
        wait_rsp(0, r + 1, 1000);
        chk("t1_latency", 0, rsp_cyc[0] - acc_cyc[0], 512);
        chk("t1_wire_bits", 0, cap_bits, 64'hFFFF_FFFF_5092_A5A5);
        chk("t1_rise_count", 0, cap_n, 64);
        chk("t1_rdata", 0, rsp_data[0], 16'h0000);

        // 2: read phy=0 reg=3
        cap_n = 0; r = rsp_cnt[0];
        send(0, 1'b0, 5'd0, 5'd3, 16'h0000, 1'b0);
        wait_rsp(0, r + 1, 1000);
        chk("t2_rdata", 0, rsp_data[0], 16'h0003);
        chk("t2_oe_profile", 0, cap_oe, 64'hFFFF_FFFF_FFFC_0000);

        // 3+4: write reg 5 with req_valid held, read reg 5 queued behind it
        r = rsp_cnt[0]; base_acc = dut_acc[0];
        send(0, 1'b1, 5'd0, 5'd5, 16'h1234, 1'b1);
        req_we[0] = 1'b0; req_wdata[0] = 16'hFFFF;
        a = m_acc_cnt[0];
        wait_rsp(0, r + 1, 1000);
        chk("t4_accepts_in_frame", 0, dut_acc[0] - base_acc, 1);
        n = 0;
        while (m_acc_cnt[0] == a && n < 10) begin @(posedge board_clk); #1; n++; end
        req_valid[0] = 1'b0;
        chk("t3_idle_gap", 0, acc_cyc[0] - rsp_cyc[0] - 1, 1);
        wait_rsp(0, r + 2, 1000);
        chk("t3_rdata", 0, rsp_data[0], 16'h1234);

        // 5: reset during DATA of a write to reg 7
        r = rsp_cnt[0];
        send(0, 1'b1, 5'd0, 5'd7, 16'hBEEF, 1'b0);
        repeat (416) @(posedge board_clk);
        @(negedge board_clk); #3 rst_n = 1'b0;
        #1 check_reset_outputs("t5_async");
        repeat (2) @(negedge board_clk);
        #3 rst_n = 1'b1;
        repeat (2) @(negedge board_clk);
        chk("t5_no_rsp", 0, rsp_cnt[0] - r, 0);
        send(0, 1'b0, 5'd0, 5'd7, 16'h0000, 1'b0);
        wait_rsp(0, r + 1, 1000);
        chk("t5_rdata", 0, rsp_data[0], 16'h0007);

        // 6: no preamble, slowest MDC
        capb_n = 0; r = rsp_cnt[1];
        send(1, 1'b1, 5'd2, 5'd9, 16'h0F0F, 1'b0);
        wait_rsp(1, r + 1, 20000);
        chk("t6_latency", 1, rsp_cyc[1] - acc_cyc[1], 16320);
        chk("t6_first_bit", 1, capb_first, 0);
        chk("t6_rise_count", 1, capb_n, 32);
        chk("t6_rdata", 1, rsp_data[1], 16'h0000);

        repeat (4) @(negedge board_clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
